fsm_equiv_ctrl: RTL and testbench
=================================

# fsm_equiv_ctrl

Sequencer for equivalence checking of two Mealy state machines that share a single input `x`. Examples are the 8-state original diagram and its state-reduced version. The block holds both machines in reset, then streams a stored input pattern into them one bit per clock. Each cycle it compares their `y` outputs, counts disagreements and reports the index of the first one. It sits above the two machine instances in the activity top level and owns their reset and `x` inputs.

## Interface
Parameters:
- `PAT_W`, 16: maximum pattern length in bits.
- `LEN_W`, `$clog2(PAT_W+1)`: width of length, counters and indices (derived; do not override).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request, sampled only in IDLE.
- `abort` in 1: cancel a run in progress.
- `stop_on_err` in 1: end the run at the first mismatch; latched at start.
- `pattern` in PAT_W: stimulus bits, applied LSB first; latched at start.
- `length` in LEN_W: number of bits to apply; latched at start; values above PAT_W clamp to PAT_W.
- `y_a` in 1: Mealy output of machine A (combinational from its state and `fsm_x`).
- `y_b` in 1: Mealy output of machine B.
- `fsm_rst` out 1: active-high reset driven to both machines.
- `fsm_x` out 1: shared input `x` to both machines.
- `busy` out 1: high in CLR and RUN.
- `done` out 1: one-cycle pulse when a run completes normally.
- `mismatch_cnt` out LEN_W: number of RUN cycles with `y_a != y_b`.
- `first_err_valid` out 1: at least one mismatch was recorded.
- `first_err_idx` out LEN_W: bit index of the first mismatch.

## Operation
- Controller states (`ctrl_state_t`):
  - IDLE → CLR on `start`.
  - CLR → RUN if the clamped length is at least 1, else → DONE.
  - RUN → DONE after the last bit, or after the first mismatch when `stop_on_err` is latched.
  - DONE → IDLE unconditionally.
- Entry to CLR:
  - Latch `pattern`, clamped `length` and `stop_on_err`.
  - Clear the bit cursor, `mismatch_cnt`, `first_err_valid` and `first_err_idx`.
- RUN, cursor k:
  - `fsm_x = pattern[k]`.
  - If `y_a != y_b`: increment `mismatch_cnt`; if `first_err_valid` is 0, set it and load `first_err_idx = k`.
  - The cursor advances every RUN cycle.
- `fsm_rst` is 1 in IDLE, CLR and DONE, and 0 only in RUN. Both machines therefore start the run in their reset state.
- `fsm_x` is 0 outside RUN.
- Result registers hold their values from DONE until the next CLR.
- `mismatch_cnt` cannot overflow: at most PAT_W increments per run.
- Abort:
  - `abort` in CLR, RUN or DONE → IDLE on the next edge, with no `done` pulse; partial results are held.
  - `abort` in IDLE has no effect, and `start` wins when both are high.
- `start` while `busy` or in DONE is ignored; it is not queued.

## Timing
- Reset value of every output:
  - `fsm_rst=1`.
  - `fsm_x=0`, `busy=0`, `done=0`.
  - `mismatch_cnt=0`, `first_err_valid=0`, `first_err_idx=0`.
  - State is IDLE.
- `reset_n` low mid-run forces reset values asynchronously; no `done` pulse.
- `start` sampled at edge t:
  - CLR occupies cycle t+1.
  - RUN occupies t+2 .. t+1+L.
  - DONE (`done=1`) occurs at t+2+L.
- `length=0`: `done` at t+2; `fsm_x` never toggles.
- `stop_on_err` with first mismatch at index k: DONE at t+3+k. The counter includes that mismatch.
- Comparison is same-cycle combinational: `y_a`/`y_b` are sampled at the edge that also advances both machines.
- Outputs are registered, except `fsm_x` (decoded from state and cursor) and `fsm_rst` (decoded from state).

## Structure
- `equiv_pkg`: `ctrl_state_t` (`logic [1:0]`: IDLE, CLR, RUN, DONE).
- One sub-module, `equiv_bit_cursor`:
  - Function: LEN_W index counter with clear and enable.
  - Outputs: current index and a `last` flag (index == clamped length − 1).
- The top level holds the FSM, the pattern/length/mode latches and the result registers.

## Test plan
- Equal outputs: `pattern=16'h00A5`, `length=8`, `y_b=y_a`.
  - `fsm_x` sequence 1,0,1,0,0,1,0,1.
  - `done` at t+10; `mismatch_cnt=0`, `first_err_valid=0`.
- Injected mismatches: same stimulus, `y_b` inverted at indices 3 and 6.
  - `mismatch_cnt=2`, `first_err_idx=3`, `first_err_valid=1`; `done` at t+10.
- Early stop: same as the previous scenario with `stop_on_err=1`.
  - `done` at t+6, `mismatch_cnt=1`, `first_err_idx=3`.
  - `fsm_rst=1` from t+6 onward.
- Length edge cases:
  - `length=0` → `done` at t+2, `fsm_x` stays 0.
  - `length=20` with `PAT_W=16` → 16 RUN cycles, `done` at t+18.
- Abort: `abort` asserted during RUN at index 2.
  - Next cycle: IDLE, `busy=0`, no `done`, `fsm_rst=1`; partial counts held.
  - `start` during that RUN is ignored.
- Reset: `reset_n` low during RUN.
  - All outputs take their reset values immediately.
  - After release, a new `start` completes a normal run.

Source files
------------

// File: rtl/equiv_pkg.sv
// Shared types for the Mealy-machine equivalence sequencer.
package equiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/equiv_bit_cursor.sv
// Pattern bit cursor: synchronous clear, advance on enable, flags the final bit.
module equiv_bit_cursor #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] idx,
  output logic             last
);

  logic [LEN_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // len is never 0 while the cursor is enabled, so the wrap of len-1 is harmless
  assign idx  = idx_q;
  assign last = (idx_q == (len - LEN_W'(1)));

endmodule

// File: rtl/fsm_equiv_ctrl.sv
// Streams a stored pattern into two Mealy machines and tallies output disagreements.
// States: IDLE wait for start | CLR machines held in reset | RUN stream bits | DONE report
module fsm_equiv_ctrl #(
  parameter  int PAT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stop_on_err,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             y_a,
  input  logic             y_b,
  output logic             fsm_rst,
  output logic             fsm_x,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] mismatch_cnt,
  output logic             first_err_valid,
  output logic [LEN_W-1:0] first_err_idx
);

  import equiv_pkg::*;

  ctrl_state_t      state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             err_valid_q, err_valid_d;
  logic [LEN_W-1:0] err_idx_q, err_idx_d;

  logic [LEN_W-1:0] len_clamp;
  logic [LEN_W-1:0] cur_idx;
  logic             cur_last;
  logic             cur_clr;
  logic             cur_en;
  logic             y_diff;
  logic [PAT_W-1:0] pat_shift;

  assign len_clamp = (length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : length;
  assign y_diff    = y_a ^ y_b;

  equiv_bit_cursor #(
    .LEN_W (LEN_W)
  ) u_cursor (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cur_clr),
    .en      (cur_en),
    .len     (len_q),
    .idx     (cur_idx),
    .last    (cur_last)
  );

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    stop_d      = stop_q;
    mis_cnt_d   = mis_cnt_q;
    err_valid_d = err_valid_q;
    err_idx_d   = err_idx_q;
    cur_clr     = 1'b0;
    cur_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLR;
          pattern_d   = pattern;
          len_d       = len_clamp;
          stop_d      = stop_on_err;
          mis_cnt_d   = '0;
          err_valid_d = 1'b0;
          err_idx_d   = '0;
          cur_clr     = 1'b1;
        end
      end
      CLR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (len_q != '0) begin
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: begin
        cur_en = 1'b1;
        // an aborted cycle leaves the partial results exactly as they were
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (y_diff) begin
            mis_cnt_d = mis_cnt_q + LEN_W'(1);
            if (!err_valid_q) begin
              err_valid_d = 1'b1;
              err_idx_d   = cur_idx;
            end
          end
          if (cur_last || (stop_q && y_diff)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CLR) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mis_cnt_q   <= mis_cnt_d;
      err_valid_q <= err_valid_d;
      err_idx_q   <= err_idx_d;
    end
  end

  // x and the machine reset are decoded so both machines see the bit in the same cycle it is compared
  assign pat_shift = pattern_q >> cur_idx;
  assign fsm_x     = (state_q == RUN) && pat_shift[0];
  assign fsm_rst   = (state_q != RUN);

  assign busy            = busy_q;
  assign done            = done_q;
  assign mismatch_cnt    = mis_cnt_q;
  assign first_err_valid = err_valid_q;
  assign first_err_idx   = err_idx_q;

endmodule

// File: tb/tb_fsm_equiv_ctrl.sv
// Directed bench for fsm_equiv_ctrl: hand-computed cycle timing and result values.
module tb_fsm_equiv_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        stop_on_err;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic        y_a;
  logic        y_b;
  logic        fsm_rst;
  logic        fsm_x;
  logic        busy;
  logic        done;
  logic [4:0]  mismatch_cnt;
  logic        first_err_valid;
  logic [4:0]  first_err_idx;

  int pass_cnt = 0;
  int total_cnt = 0;

  fsm_equiv_ctrl #(.PAT_W(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .stop_on_err     (stop_on_err),
    .pattern         (pattern),
    .length          (length),
    .y_a             (y_a),
    .y_b             (y_b),
    .fsm_rst         (fsm_rst),
    .fsm_x           (fsm_x),
    .busy            (busy),
    .done            (done),
    .mismatch_cnt    (mismatch_cnt),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at edge t, then walk cycles t+1, t+2, ... recording when done shows and what x was streamed.
  task automatic run(input logic [15:0] pat, input logic [4:0] len, input logic stop,
                     input logic [15:0] inj, output int done_cyc, output logic [15:0] xseq,
                     output int nrun);
    done_cyc    = -1;
    xseq        = '0;
    nrun        = 0;
    pattern     = pat;
    length      = len;
    stop_on_err = stop;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (!fsm_rst) begin
        y_a = 1'($urandom_range(0, 1));
        if (nrun < 16) begin
          xseq[nrun] = fsm_x;
          y_b        = y_a ^ inj[nrun];
        end else begin
          y_b = y_a;
        end
        nrun++;
      end else begin
        y_a = 1'b0;
        y_b = 1'b0;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    y_a = 1'b0;
    y_b = 1'b0;
    tick();
  endtask

  initial begin
    int          dcyc;
    logic [15:0] xs;
    int          nr;
    logic        saw_busy;
    logic        saw_done;

    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    stop_on_err = 1'b0;
    pattern     = '0;
    length      = '0;
    y_a         = 1'b0;
    y_b         = 1'b0;
    #3;
    chk("rst_fsm_rst", fsm_rst, 1);
    chk("rst_fsm_x", fsm_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_valid", first_err_valid, 0);
    chk("rst_idx", first_err_idx, 0);
    #17;
    reset_n = 1'b1;
    tick();

    // equal outputs
    run(16'h00A5, 5'd8, 1'b0, 16'h0000, dcyc, xs, nr);
    chk("eq_done_cyc", dcyc, 10);
    chk("eq_xseq", xs, 16'h00A5);
    chk("eq_nrun", nr, 8);
    chk("eq_cnt", mismatch_cnt, 0);
    chk("eq_valid", first_err_valid, 0);
    chk("eq_done_pulse", done, 0);

    // mismatches at indices 3 and 6
    run(16'h00A5, 5'd8, 1'b0, 16'h0048, dcyc, xs, nr);
    chk("mm_done_cyc", dcyc, 10);
    chk("mm_cnt", mismatch_cnt, 2);
    chk("mm_idx", first_err_idx, 3);
    chk("mm_valid", first_err_valid, 1);

    // early stop on first mismatch
    run(16'h00A5, 5'd8, 1'b1, 16'h0048, dcyc, xs, nr);
    chk("es_done_cyc", dcyc, 6);
    chk("es_nrun", nr, 4);
    chk("es_cnt", mismatch_cnt, 1);
    chk("es_idx", first_err_idx, 3);
    chk("es_rst_after", fsm_rst, 1);
    tick();
    tick();
    chk("es_cnt_held", mismatch_cnt, 1);
    chk("es_rst_held", fsm_rst, 1);

    // zero length
    run(16'hFFFF, 5'd0, 1'b0, 16'h0000, dcyc, xs, nr);
    chk("l0_done_cyc", dcyc, 2);
    chk("l0_nrun", nr, 0);
    chk("l0_cnt_cleared", mismatch_cnt, 0);
    chk("l0_valid_cleared", first_err_valid, 0);

    // length clamps to 16
    run(16'hBEEF, 5'd20, 1'b0, 16'h0000, dcyc, xs, nr);
    chk("l20_done_cyc", dcyc, 18);
    chk("l20_nrun", nr, 16);
    chk("l20_xseq", xs, 16'hBEEF);
    chk("l20_cnt", mismatch_cnt, 0);

    // abort at index 2 after a mismatch at index 1; a start in the same cycle is dropped
    pattern     = 16'h00A5;
    length      = 5'd8;
    stop_on_err = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    y_a = 1'b0; y_b = 1'b0;
    tick();
    y_a = 1'b0; y_b = 1'b1;
    tick();
    y_a = 1'b0; y_b = 1'b0;
    chk("ab_in_run", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_fsm_rst", fsm_rst, 1);
    chk("ab_cnt", mismatch_cnt, 1);
    chk("ab_idx", first_err_idx, 1);
    chk("ab_valid", first_err_valid, 1);
    saw_busy = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_busy |= busy;
      saw_done |= done;
    end
    chk("ab_no_queued_start", saw_busy, 0);
    chk("ab_no_done", saw_done, 0);

    // asynchronous reset mid-run
    pattern = 16'h00A5;
    length  = 5'd8;
    start   = 1'b1;
    tick();
    start = 1'b0;
    y_a   = 1'b0;
    y_b   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rr_cnt_before", mismatch_cnt, 4);
    chk("rr_busy_before", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rr_fsm_rst", fsm_rst, 1);
    chk("rr_fsm_x", fsm_x, 0);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_cnt", mismatch_cnt, 0);
    chk("rr_valid", first_err_valid, 0);
    chk("rr_idx", first_err_idx, 0);
    y_a = 1'b0;
    y_b = 1'b0;
    #10;
    reset_n = 1'b1;
    tick();
    run(16'h00A5, 5'd8, 1'b0, 16'h0040, dcyc, xs, nr);
    chk("rr_rerun_done_cyc", dcyc, 10);
    chk("rr_rerun_cnt", mismatch_cnt, 1);
    chk("rr_rerun_idx", first_err_idx, 6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
